// File: rtl/useq_loop_ctrl.sv
// Microsequencer loop controller: registered microcode address with
// NUM_LOOPS independent counted-loop levels (start marker / end marker pairs).
module useq_loop_ctrl #(
  parameter int UINST_ADDR_WIDTH = 9,
  parameter int CNT_WIDTH        = 11,
  parameter int NUM_LOOPS        = 8,
  localparam int IDX_W           = $clog2(NUM_LOOPS)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [UINST_ADDR_WIDTH-1:0]    upc_start,
  input  logic                           done,
  input  logic                           stall,
  input  logic [NUM_LOOPS*CNT_WIDTH-1:0] loop_init,
  input  logic                           st_en,
  input  logic [IDX_W-1:0]               st_idx,
  input  logic                           up_en,
  input  logic [IDX_W-1:0]               up_idx,
  output logic [UINST_ADDR_WIDTH-1:0]    upc,
  output logic                           busy,
  output logic                           loop_err,
  output logic                           dbg_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [IDX_W:0] NL = (IDX_W+1)'(NUM_LOOPS);

  state_e                      state_q, state_d;
  logic [UINST_ADDR_WIDTH-1:0] upc_q, upc_d;
  logic [UINST_ADDR_WIDTH-1:0] addr_q [NUM_LOOPS];
  logic [UINST_ADDR_WIDTH-1:0] addr_d [NUM_LOOPS];
  logic [CNT_WIDTH-1:0]        cnt_q  [NUM_LOOPS];
  logic [CNT_WIDTH-1:0]        cnt_d  [NUM_LOOPS];
  logic [CNT_WIDTH-1:0]        init_a [NUM_LOOPS];
  logic                        err_q, err_d;

  logic                        run, st_v, up_v, upd_en, do_clear;
  logic [CNT_WIDTH-1:0]        cnt_cur, cnt_dec, st_init;

  always_comb begin
    for (int i = 0; i < NUM_LOOPS; i++) begin
      init_a[i] = loop_init[i*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  // start and done are single-cycle strobes with no handshake; both act even
  // while stall is high, whereas loop markers only act in RUN without stall.
  always_comb begin
    run      = (state_q == RUN);
    st_v     = st_en && ({1'b0, st_idx} < NL);
    up_v     = up_en && ({1'b0, up_idx} < NL);
    cnt_cur  = up_v ? cnt_q[up_idx] : '0;
    cnt_dec  = cnt_cur - CNT_WIDTH'(1);
    st_init  = st_v ? init_a[st_idx] : '0;
    upd_en   = run && !stall && !start && !done;
    do_clear = run && done && !start;

    // Jump decision always uses the pre-store registers.
    upc_d = upc_q + UINST_ADDR_WIDTH'(1);
    if (start) begin
      upc_d = upc_start;
    end else if (done) begin
      upc_d = '0;
    end else if (!run || stall) begin
      upc_d = upc_q;
    end else if (up_v && (cnt_dec != '0)) begin
      upc_d = addr_q[up_idx];
    end

    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else if (done) begin
      state_d = IDLE;
    end

    err_d = err_q;
    if (start) begin
      err_d = 1'b0;
    end else if (upd_en && st_v && (st_init == '0)) begin
      err_d = 1'b1;
    end

    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (do_clear) begin
      for (int i = 0; i < NUM_LOOPS; i++) begin
        addr_d[i] = '0;
        cnt_d[i]  = '0;
      end
    end else if (upd_en) begin
      if (up_v) begin
        cnt_d[up_idx] = cnt_dec;
      end
      // Applied after the decrement so a same-level store wins.
      if (st_v) begin
        addr_d[st_idx] = upc_q;
        cnt_d[st_idx]  = (st_init == '0) ? CNT_WIDTH'(1) : st_init;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      upc_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_LOOPS; i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign upc       = upc_q;
  assign busy      = (state_q == RUN);
  assign loop_err  = err_q;
  assign dbg_state = state_q;

endmodule
